contador_botones_2b: RTL and testbench
======================================

Name: contador_botones_2b

Overview:
- Upstream stage of the 7-segment decoder. Turns two raw push-buttons (up/down) into the 2-bit value `valor` that drives the decoder input directly.
- Each button is synchronised and debounced, and one step is counted per debounced press.
- Also produces a one-cycle change strobe for other consumers, e.g. a blink or LED indicator.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive cycles the synchronised input must hold a new level before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser. Legal range is 2 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- btn_up  in  1  raw asynchronous button, active-high; a press increments the value
- btn_down  in  1  raw asynchronous button, active-high; a press decrements the value
- valor  out  2  current count, registered; connects directly to the decoder's `valor`
- cambio  out  1  one-cycle pulse, asserted in the same cycle `valor` takes a new value

Behaviour:
- Reset: one clock; synchronous, active-high reset (`rst` sampled on the `clk` rising edge).
  - Clears synchronisers, debounce counters, FSMs and outputs.
  - `valor` = 0, `cambio` = 0, both FSMs = SUELTO.
  - Reset takes priority over all other activity in the same cycle.
- Synchroniser: a SYNC_STAGES-deep flip-flop chain per button. `s_up` and `s_down` denote the final-stage outputs.
- Debounce FSM, one instance per button, each with its own counter sized ceil(log2(DEBOUNCE_CYCLES)) + 1 bits:
  - SUELTO (released): if s = 1, go to ESPERA_PULSA with cnt = 1; otherwise stay.
  - ESPERA_PULSA: if s = 0, return to SUELTO with cnt = 0. Else if cnt = DEBOUNCE_CYCLES - 1, go to PULSADO and emit a one-cycle press pulse. Else cnt++.
  - PULSADO: if s = 0, go to ESPERA_SUELTA with cnt = 1; otherwise stay. No further pulses while held.
  - ESPERA_SUELTA: if s = 1, return to PULSADO with cnt = 0. Else if cnt = DEBOUNCE_CYCLES - 1, go to SUELTO with cnt = 0. Else cnt++.
- Counter update, evaluated on the cycle after the press pulses are produced:
  - up pulse only: `valor` <= `valor` + 1, modulo 4 (3 -> 0).
  - down pulse only: `valor` <= `valor` - 1, modulo 4 (0 -> 3).
  - both pulses in the same cycle: `valor` unchanged, `cambio` = 0.
  - `cambio` is registered and is 1 for exactly the one cycle in which the new `valor` is first visible.
- Latency: if the button is first sampled high at edge k and held, `valor` and `cambio` update at edge k + SYNC_STAGES + DEBOUNCE_CYCLES. The latency is fixed and must not vary with press history.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES on the synchronised input produces no step.
- Release: release is debounced with the same threshold, so bounce on release cannot create a second press.
- Reset mid-operation:
  - Any partial debounce is discarded.
  - A button held through reset deassertion is seen as a new press and produces exactly one step, with the latency above counted from the first post-reset sample.
- Independence: the two buttons are fully independent. One button held in PULSADO does not block the other.

Optional Feature:
- Macro: CONTADOR_SATURATE_EN.
- Defined: the count saturates instead of wrapping.
  - An up press at 3 leaves `valor` = 3 and `cambio` = 0.
  - A down press at 0 leaves `valor` = 0 and `cambio` = 0.
- Undefined: modulo-4 wrap as specified above.
- All other behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES = 4, SYNC_STAGES = 2):
- Idle: `rst` for 3 cycles, then buttons low for 30 cycles -> `valor` = 0 throughout, `cambio` never asserted.
- Single press: `btn_up` high for 20 cycles, first sampled at edge k -> `valor` goes 0 -> 1 at edge k+6, `cambio` = 1 only in that cycle. After release, `valor` stays 1.
- Bounce: `btn_up` toggles every 2 cycles for 16 cycles, then stays low -> `valor` stays 0 and `cambio` stays 0. A glitch of exactly 3 synchronised cycles also gives no step.
- Wrap: four clean up presses -> `valor` 1, 2, 3, 0, with four `cambio` pulses. Then one down press -> `valor` = 3.
  - With CONTADOR_SATURATE_EN defined: the 4th up press leaves `valor` at 3 with no pulse; a down press from 0 stays 0.
- Simultaneous: `btn_up` and `btn_down` rise on the same edge and are held 10 cycles -> `valor` unchanged, no `cambio`. Staggered by 1 cycle -> still no net change, with one `cambio` pulse per step.
- Reset mid-debounce: `btn_up` high, `rst` pulsed 2 cycles after the first sample while the button stays high -> `valor` = 0 after reset, then exactly one step to 1, 6 edges after the first post-reset sample.

Source files
------------

// File: rtl/contador_botones_2b.sv
// rtl/contador_botones_2b.sv - debounced up/down buttons driving a registered 2-bit count
// Optional build macro CONTADOR_SATURATE_EN: count saturates at 0 and 3 instead of wrapping.

module contador_botones_2b_antirrebote #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulso
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SUELTO,
        ESPERA_PULSA,
        PULSADO,
        ESPERA_SUELTA
    } estado_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    estado_t                estado, estado_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   pulso_n;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= '0;
            estado <= SUELTO;
            cnt    <= '0;
            pulso  <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], btn};
            estado <= estado_n;
            cnt    <= cnt_n;
            pulso  <= pulso_n;
        end
    end

    // The press pulse is registered so the overall latency stays SYNC_STAGES + DEBOUNCE_CYCLES.
    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        pulso_n  = 1'b0;
        case (estado)
            SUELTO: begin
                if (s) begin
                    estado_n = ESPERA_PULSA;
                    cnt_n    = CW'(1);
                end
            end
            ESPERA_PULSA: begin
                if (!s) begin
                    estado_n = SUELTO;
                    cnt_n    = '0;
                end else if (cnt == CNT_MAX) begin
                    estado_n = PULSADO;
                    cnt_n    = '0;
                    pulso_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PULSADO: begin
                if (!s) begin
                    estado_n = ESPERA_SUELTA;
                    cnt_n    = CW'(1);
                end
            end
            ESPERA_SUELTA: begin
                if (s) begin
                    estado_n = PULSADO;
                    cnt_n    = '0;
                end else if (cnt == CNT_MAX) begin
                    estado_n = SUELTO;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                estado_n = SUELTO;
                cnt_n    = '0;
            end
        endcase
    end
endmodule

module contador_botones_2b #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] valor,
    output logic       cambio
);
    logic       pulso_up, pulso_down;
    logic [1:0] valor_n;

    contador_botones_2b_antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_up (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_up),
        .pulso(pulso_up)
    );

    contador_botones_2b_antirrebote #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_down (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_down),
        .pulso(pulso_down)
    );

    // Simultaneous up and down pulses cancel out.
    always_comb begin
        valor_n = valor;
        case ({pulso_up, pulso_down})
            2'b10: begin
`ifdef CONTADOR_SATURATE_EN
                if (valor != 2'd3) valor_n = valor + 2'd1;
`else
                valor_n = valor + 2'd1;
`endif
            end
            2'b01: begin
`ifdef CONTADOR_SATURATE_EN
                if (valor != 2'd0) valor_n = valor - 2'd1;
`else
                valor_n = valor - 2'd1;
`endif
            end
            default: valor_n = valor;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valor  <= 2'd0;
            cambio <= 1'b0;
        end else begin
            valor  <= valor_n;
            cambio <= (valor_n != valor);
        end
    end
endmodule

// File: tb/tb_contador_botones_2b.sv
// tb/tb_contador_botones_2b.sv - scoreboard bench for contador_botones_2b against a run-length button model

module tb_contador_botones_2b;
    localparam int D = 4;
    localparam int S = 2;

`ifdef CONTADOR_SATURATE_EN
    localparam int WRAP_FINAL  = 2;
    localparam int WRAP_PULSES = 4;
    localparam int DOWN_AT_0   = 0;
`else
    localparam int WRAP_FINAL  = 3;
    localparam int WRAP_PULSES = 5;
    localparam int DOWN_AT_0   = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] valor;
    logic       cambio;

    contador_botones_2b #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .valor   (valor),
        .cambio  (cambio)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int c;
    } exp_t;

    exp_t q[$];
    int   nchecks = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   mvalor = 0;
    int   ncambio = 0;
    int   last_cambio = -1;

    // Model: each button's accepted level flips after D consecutive contrary samples
    // of the raw input delayed by S edges; a flip to 1 steps the count one edge later.
    bit   hist[2][S];
    bit   acc[2];
    int   run[2];
    bit   pend[2];

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        bit raw[2];
        bit seen;
        int nv;
        cyc++;
        raw[0] = btn_up;
        raw[1] = btn_down;
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < S; i++) hist[b][i] = 1'b0;
                acc[b]  = 1'b0;
                run[b]  = 0;
                pend[b] = 1'b0;
            end
            mvalor = 0;
        end else begin
            if (pend[0] != pend[1]) begin
`ifdef CONTADOR_SATURATE_EN
                if (pend[0]) nv = (mvalor == 3) ? 3 : mvalor + 1;
                else         nv = (mvalor == 0) ? 0 : mvalor - 1;
`else
                if (pend[0]) nv = (mvalor + 1) % 4;
                else         nv = (mvalor + 3) % 4;
`endif
                if (nv != mvalor) q.push_back('{nv, cyc});
                mvalor = nv;
            end
            for (int b = 0; b < 2; b++) begin
                seen    = hist[b][S-1];
                pend[b] = 1'b0;
                if (seen != acc[b]) begin
                    run[b]++;
                    if (run[b] == D) begin
                        acc[b]  = seen;
                        run[b]  = 0;
                        pend[b] = seen;
                    end
                end else begin
                    run[b] = 0;
                end
                for (int i = S - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
                hist[b][0] = raw[b];
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        check("valor", int'(valor), mvalor);
        if (cambio) begin
            ncambio++;
            last_cambio = cyc;
            if (q.size() == 0) begin
                check("cambio_spurious", 1, 0);
            end else begin
                e = q.pop_front();
                check("cambio_valor", int'(valor), e.v);
                check("cambio_cycle", cyc, e.c);
            end
        end else if (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            check("cambio_missing", 0, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic press(input bit up);
        if (up) btn_up = 1'b1;
        else    btn_down = 1'b1;
        tick(8);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(8);
    endtask

    initial begin
        int k;
        int c0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset_valor", int'(valor), 0);
        check("reset_cambio", int'(cambio), 0);

        c0 = ncambio;
        tick(30);
        check("idle_valor", int'(valor), 0);
        check("idle_cambio_count", ncambio - c0, 0);

        btn_up = 1'b1;
        k = cyc + 1;
        tick(20);
        btn_up = 1'b0;
        tick(10);
        check("single_latency", last_cambio, k + S + D);
        check("single_count", ncambio - c0, 1);
        check("single_valor", int'(valor), 1);

        c0 = ncambio;
        for (int i = 0; i < 8; i++) begin
            btn_up = ~btn_up;
            tick(2);
        end
        btn_up = 1'b0;
        tick(10);
        btn_up = 1'b1;
        tick(D - 1);
        btn_up = 1'b0;
        tick(10);
        check("bounce_glitch_count", ncambio - c0, 0);
        check("bounce_glitch_valor", int'(valor), 1);

        do_reset(1);
        c0 = ncambio;
        for (int i = 0; i < 4; i++) press(1'b1);
        press(1'b0);
        check("wrap_valor", int'(valor), WRAP_FINAL);
        check("wrap_count", ncambio - c0, WRAP_PULSES);

        do_reset(1);
        press(1'b0);
        check("down_at_zero", int'(valor), DOWN_AT_0);

        do_reset(1);
        press(1'b1);
        c0 = ncambio;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        tick(10);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(10);
        check("simul_valor", int'(valor), 1);
        check("simul_count", ncambio - c0, 0);

        btn_up = 1'b1;
        tick(1);
        btn_down = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(1);
        btn_down = 1'b0;
        tick(10);
        check("stagger_valor", int'(valor), 1);
        check("stagger_count", ncambio - c0, 2);

        do_reset(1);
        c0 = ncambio;
        btn_up = 1'b1;
        k = cyc + 1;
        tick(2);
        do_reset(1);
        tick(20);
        btn_up = 1'b0;
        tick(10);
        check("midreset_latency", last_cambio, k + 3 + S + D);
        check("midreset_count", ncambio - c0, 1);
        check("midreset_valor", int'(valor), 1);

        for (int i = 0; i < 60; i++) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 10));
            if (i == 30) do_reset(1);
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(20);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end
endmodule
